// File: rtl/radix2_pkg.sv
// Shared definitions for the radix-2 arithmetic unit (multiplier and divider).
// Holds the common FSM encoding, the default operand width and the magnitude helper.
package radix2_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAG_W         = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Callers zero-extend into MAG_W bits and truncate back to their own width.
    function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-1:0] v, input logic neg);
        return neg ? (~v + MAG_W'(1)) : v;
    endfunction

endpackage

// File: rtl/radix2_mul_if.sv
// Operand/result bundle for the radix-2 multiplier.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
interface radix2_mul_if import radix2_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic                 sign;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 opn_valid;
    logic                 opn_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output sign, multiplicand, multiplier, opn_valid, res_ready,
        input  opn_ready, res_valid, result
    );

    modport slave (
        input  sign, multiplicand, multiplier, opn_valid, res_ready,
        output opn_ready, res_valid, result
    );

endinterface

// File: rtl/radix2_abs.sv
// Unsigned magnitude and negative flag of a WIDTH-bit operand; the most-negative value
// maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
module radix2_abs import radix2_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] val,
    input  logic             sign,
    output logic [WIDTH-1:0] mag,
    output logic             neg
);

    assign neg = sign & val[WIDTH-1];
    assign mag = WIDTH'(abs_mag(MAG_W'(val), neg));

endmodule

// File: rtl/radix2_mul.sv
// Sequential radix-2 shift-add multiplier: WIDTH iterations on operand magnitudes,
// sign fixed up when the product is loaded into the result register.
module radix2_mul import radix2_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    radix2_mul_if.slave       bus,
    output state_t            dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mag_a, mplr, acc;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;
    logic                 res_valid_q;
    logic [2*WIDTH-1:0]   result_q;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic                 neg_a, neg_b;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     acc_next, mplr_next;
    logic [2*WIDTH-1:0]   prod;
    logic                 accept, last, release_res;

    radix2_abs #(.WIDTH(WIDTH)) u_abs_a (
        .val  (bus.multiplicand),
        .sign (bus.sign),
        .mag  (abs_a),
        .neg  (neg_a)
    );

    radix2_abs #(.WIDTH(WIDTH)) u_abs_b (
        .val  (bus.multiplier),
        .sign (bus.sign),
        .mag  (abs_b),
        .neg  (neg_b)
    );

    assign accept      = (state_q == IDLE) && bus.opn_valid;
    assign last        = (state_q == BUSY) && (cnt == CNT_W'(WIDTH - 1));
    assign release_res = (state_q == DONE) && bus.res_ready;

    // The multiplier register doubles as the low half of the product as bits shift in.
    assign sum       = {1'b0, acc} + (mplr[0] ? {1'b0, mag_a} : '0);
    assign acc_next  = sum[WIDTH:1];
    assign mplr_next = {sum[0], mplr[WIDTH-1:1]};
    assign prod      = {acc_next, mplr_next};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.opn_valid) state_d = BUSY;
            BUSY:    if (last)          state_d = DONE;
            DONE:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a       <= '0;
            mplr        <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            if (accept) begin
                mag_a <= abs_a;
                mplr  <= abs_b;
                neg   <= neg_a ^ neg_b;
                acc   <= '0;
                cnt   <= '0;
            end else if (state_q == BUSY) begin
                acc  <= acc_next;
                mplr <= mplr_next;
                cnt  <= cnt + CNT_W'(1);
            end
            if (last) begin
                result_q    <= neg ? -prod : prod;
                res_valid_q <= 1'b1;
            end else if (release_res) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.opn_ready = (state_q == IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;
    assign dbg_state     = state_q;

endmodule
